imem_fetch_port: RTL and testbench

Parametrised, byte-addressed instruction memory with a valid/ready fetch channel and a byte-wide programming port. It sits between the fetch stage and instruction storage.
- Fetch side: registered reads, one response slot, one accepted request per cycle at full throughput.
- Error reporting: misaligned and out-of-range fetches are flagged.
- Programming: contents are loaded through the programming port, not re-initialised on reset.

---
 rtl/imem_fetch_port.sv | 102 ++++++++++
 tb/tb_imem_fetch_port.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/imem_fetch_port.sv
// Byte-addressed instruction memory with a single-slot registered fetch channel
// and a byte-wide programming port that is only honoured once fetches have drained.
module imem_fetch_port #(
   parameter int DATA_W      = 32,
   parameter int DEPTH_BYTES = 1024,
   parameter int ADDR_W      = 32,
   parameter bit BIG_ENDIAN  = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] req_addr,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_data,
   output logic              rsp_err,
   input  logic              prog_en,
   output logic              prog_ready,
   input  logic              prog_we,
   input  logic [ADDR_W-1:0] prog_addr,
   input  logic [7:0]        prog_data
);
   localparam int B  = DATA_W / 8;
   localparam int A  = $clog2(B);
   localparam int MA = (DEPTH_BYTES > 1) ? $clog2(DEPTH_BYTES) : 1;

   typedef enum logic [1:0] {RUN, DRAIN, PROG} state_t;

   state_t            state_q, state_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
   logic              rsp_err_q, rsp_err_d;
   logic [7:0]        mem_q [DEPTH_BYTES];
   logic [DATA_W-1:0] rd_word;
   logic              accept, fetch_err, mem_we;

   assign req_ready  = rst_n && (state_q == RUN) && !prog_en && (!rsp_valid_q || rsp_ready);
   assign accept     = req_valid && req_ready;
   assign prog_ready = (state_q == PROG);
   assign rsp_valid  = rsp_valid_q;
   assign rsp_data   = rsp_data_q;
   assign rsp_err    = rsp_err_q;

   // Range test is on the full address width so high addresses never alias into storage.
   assign fetch_err = (|req_addr[A-1:0]) || (req_addr > ADDR_W'(DEPTH_BYTES - B));
   assign mem_we    = (state_q == PROG) && prog_en && prog_we &&
                      (prog_addr < ADDR_W'(DEPTH_BYTES));

   always_comb begin
      rd_word = '0;
      for (int k = 0; k < B; k++) begin
         if (BIG_ENDIAN) rd_word[DATA_W-1-8*k -: 8] = mem_q[MA'(req_addr) + MA'(k)];
         else            rd_word[8*k +: 8]          = mem_q[MA'(req_addr) + MA'(k)];
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         RUN:   if (prog_en) state_d = rsp_valid_q ? DRAIN : PROG;
         DRAIN: begin
            if (!prog_en)                        state_d = RUN;
            else if (!rsp_valid_q || rsp_ready)  state_d = PROG;
         end
         PROG:  if (!prog_en) state_d = RUN;
         default: state_d = RUN;
      endcase
   end

   always_comb begin
      rsp_valid_d = rsp_valid_q;
      rsp_data_d  = rsp_data_q;
      rsp_err_d   = rsp_err_q;
      if (accept) begin
         rsp_valid_d = 1'b1;
         rsp_data_d  = fetch_err ? '0 : rd_word;
         rsp_err_d   = fetch_err;
      end else if (rsp_ready) begin
         rsp_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= RUN;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   // Storage survives reset; it only changes through the programming port.
   always_ff @(posedge clk) begin
      if (mem_we) mem_q[MA'(prog_addr)] <= prog_data;
   end
endmodule

// File: tb/tb_imem_fetch_port.sv
// Bench for imem_fetch_port: directed scenarios plus random traffic, with responses
// checked by a scoreboard fed from a byte-array model of the storage.
module tb_imem_fetch_port;
   localparam int DATA_W = 32;
   localparam int DEPTH  = 1024;
   localparam int ADDR_W = 32;
   localparam int B      = DATA_W / 8;

   logic              clk = 1'b0, rst_n = 1'b1;
   logic              req_valid = 1'b0, rsp_ready = 1'b1, prog_en = 1'b0, prog_we = 1'b0;
   logic [ADDR_W-1:0] req_addr = '0, prog_addr = '0;
   logic [7:0]        prog_data = '0;
   logic              req_ready, rsp_valid, rsp_err, prog_ready;
   logic [DATA_W-1:0] rsp_data;

   int n_chk = 0, n_pass = 0;
   logic [7:0] ref_mem [DEPTH];

   typedef struct {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
      logic              err;
   } exp_t;
   exp_t sb_q[$];
   exp_t mon_e;

   imem_fetch_port #(.DATA_W(DATA_W), .DEPTH_BYTES(DEPTH), .ADDR_W(ADDR_W), .BIG_ENDIAN(1'b1)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
      .prog_en(prog_en), .prog_ready(prog_ready), .prog_we(prog_we),
      .prog_addr(prog_addr), .prog_data(prog_data)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Expected fetch result: lowest-address byte first, shifted into the MSBs.
   function automatic exp_t model(input logic [ADDR_W-1:0] a);
      exp_t e;
      longint unsigned la = 64'(a);
      e.addr = a;
      e.data = '0;
      e.err  = (la % B != 0) || (la + B > DEPTH);
      if (!e.err)
         for (int k = 0; k < B; k++) e.data = (e.data << 8) | DATA_W'(ref_mem[int'(la) + k]);
      return e;
   endfunction

   function automatic logic [ADDR_W-1:0] rand_addr();
      int r = $urandom_range(0, 9);
      if (r <= 6)      return ADDR_W'($urandom_range(0, DEPTH / B - 1) * B);
      else if (r == 7) return ADDR_W'($urandom_range(0, DEPTH - 1) | 1);
      else if (r == 8) return ADDR_W'(DEPTH - B + $urandom_range(1, 12));
      else             return ADDR_W'($urandom);
   endfunction

   // Monitor: pop on every consumed response, push on every accepted request.
   always @(negedge clk) begin
      if (rst_n) begin
         if (rsp_valid && rsp_ready) begin
            if (sb_q.size() == 0) chk("sb_unexpected_rsp", 1, 0);
            else begin
               mon_e = sb_q.pop_front();
               chk($sformatf("sb_data@%0h", mon_e.addr), rsp_data, mon_e.data);
               chk($sformatf("sb_err@%0h", mon_e.addr), rsp_err, mon_e.err);
            end
         end
         if (req_valid && req_ready) sb_q.push_back(model(req_addr));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pwrite(input logic [ADDR_W-1:0] a, input logic [7:0] d, input bit honoured);
      prog_we = 1'b1; prog_addr = a; prog_data = d;
      tick();
      prog_we = 1'b0;
      if (honoured && a < DEPTH) ref_mem[int'(a)] = d;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic [ADDR_W-1:0] err_addr [5];
      logic              err_exp  [5];
      int                w;

      // Reset values, and req_ready gated while reset is asserted.
      #2 rst_n = 1'b0; req_valid = 1'b1; rsp_ready = 1'b1;
      #1;
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_data", rsp_data, 0);
      chk("rst_rsp_err", rsp_err, 0);
      chk("rst_prog_ready", prog_ready, 0);
      chk("rst_req_ready", req_ready, 0);
      tick(); tick();
      rst_n = 1'b1; req_valid = 1'b0;

      // Program every byte; bytes 0..15 hold their own address.
      prog_en = 1'b1;
      #1 chk("req_ready_prog_en", req_ready, 0);
      tick();
      chk("prog_entry", prog_ready, 1);
      for (int a = 0; a < DEPTH; a++) pwrite(ADDR_W'(a), (a < 16) ? 8'(a) : 8'($urandom), 1'b1);
      prog_en = 1'b0; prog_we = 1'b1; prog_addr = 1; prog_data = 8'hEE;
      tick();
      prog_we = 1'b0;
      chk("prog_exit", prog_ready, 0);
      chk("req_ready_after_exit", req_ready, 1);

      // Back-to-back fetches.
      req_valid = 1'b1; req_addr = 0;
      tick();
      chk("b2b_valid0", rsp_valid, 1);
      chk("b2b_data0", rsp_data, 32'h00010203);
      req_addr = 4;
      tick();
      chk("b2b_valid1", rsp_valid, 1);
      chk("b2b_data1", rsp_data, 32'h04050607);

      // Backpressure: slot holds, no new accept until rsp_ready returns.
      req_addr = 8; rsp_ready = 1'b0;
      repeat (3) begin
         #1;
         chk("bp_req_ready", req_ready, 0);
         chk("bp_data_stable", rsp_data, 32'h04050607);
         chk("bp_valid_stable", rsp_valid, 1);
         tick();
      end
      rsp_ready = 1'b1;
      #1 chk("bp_release_ready", req_ready, 1);
      tick();
      chk("bp_next_data", rsp_data, 32'h08090a0b);

      // Error and boundary fetches.
      err_addr = '{32'h2, ADDR_W'(DEPTH - 4), ADDR_W'(DEPTH), 32'hFFFF_FFFC, ADDR_W'(DEPTH - 3)};
      err_exp  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
      for (int i = 0; i < 5; i++) begin
         req_addr = err_addr[i];
         tick();
         chk($sformatf("err_flag@%0h", err_addr[i]), rsp_err, err_exp[i]);
         if (err_exp[i]) chk($sformatf("err_data@%0h", err_addr[i]), rsp_data, 0);
      end
      req_valid = 1'b0;
      tick();

      // Programming request while a response is pending: drain first.
      rsp_ready = 1'b0; req_valid = 1'b1; req_addr = 0;
      tick();
      req_valid = 1'b0;
      chk("drain_pending", rsp_valid, 1);
      prog_en = 1'b1;
      #1 chk("drain_req_ready", req_ready, 0);
      tick();
      chk("drain_prog_ready0", prog_ready, 0);
      pwrite(0, 8'h55, 1'b0);
      chk("drain_prog_ready1", prog_ready, 0);
      chk("drain_data_stable", rsp_data, 32'h00010203);
      rsp_ready = 1'b1;
      tick();
      chk("drain_to_prog", prog_ready, 1);
      chk("drain_consumed", rsp_valid, 0);
      pwrite(ADDR_W'(DEPTH + 3), 8'h77, 1'b1);
      pwrite(32'hFFFF_FFFF, 8'h66, 1'b1);
      pwrite(16, 8'hA5, 1'b1);
      prog_en = 1'b0;
      tick();
      chk("prog_exit2", prog_ready, 0);
      req_valid = 1'b1; req_addr = 0;
      tick();
      chk("oob_write_ignored", rsp_data, 32'h00010203);
      req_addr = 16;
      tick();
      req_valid = 1'b0;
      tick();

      // Reset with a response pending.
      rsp_ready = 1'b0; req_valid = 1'b1; req_addr = 4;
      tick();
      req_valid = 1'b0;
      chk("rst_mid_pending", rsp_valid, 1);
      rst_n = 1'b0;
      #1;
      chk("rst_mid_valid", rsp_valid, 0);
      chk("rst_mid_req_ready", req_ready, 0);
      sb_q.delete();
      tick(); tick();
      rst_n = 1'b1; rsp_ready = 1'b1; req_valid = 1'b1; req_addr = 0;
      tick();
      chk("rst_mid_retained", rsp_data, 32'h00010203);
      req_valid = 1'b0;
      tick();

      // Random traffic with occasional programming sessions.
      for (int it = 0; it < 600; it++) begin
         if ($urandom_range(0, 39) == 0) begin
            req_valid = 1'b0; rsp_ready = 1'b1; prog_en = 1'b1;
            w = 0;
            while (!prog_ready && w < 4) begin tick(); w++; end
            chk("rand_prog_entry", prog_ready, 1);
            if (prog_ready)
               repeat ($urandom_range(1, 6))
                  pwrite(ADDR_W'($urandom_range(0, DEPTH + 7)), 8'($urandom), 1'b1);
            prog_en = 1'b0;
            tick();
         end else begin
            req_valid = ($urandom_range(0, 3) != 0);
            req_addr  = rand_addr();
            rsp_ready = ($urandom_range(0, 3) != 0);
            tick();
         end
      end
      req_valid = 1'b0; rsp_ready = 1'b1;
      tick(); tick();
      chk("sb_drained", sb_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
